// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared definitions for the pipeline hold/flush controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: controller state encodings (3 bits, INT_ENTER encoding always
// reserved so the state width does not depend on HOLD_IRQ_EN), the hold-enable
// level and a small state classification helper.
package pipe_hold_ctrl_pkg;

  typedef enum logic [2:0] {
    HOLD_IDLE  = 3'd0,
    HOLD_FLUSH = 3'd1,
    HOLD_DIV   = 3'd2,
    HOLD_BUS   = 3'd3,
    HOLD_INT   = 3'd4
  } hold_state_t;

  // Level that asserts a hold flag on the pipeline registers.
  localparam logic HOLD_ON  = 1'b1;
  localparam logic HOLD_OFF = ~HOLD_ON;

  // Full-pipeline stalls freeze the PC as well as the bubble registers.
  function automatic logic is_stall(hold_state_t s);
    return (s == HOLD_DIV) || (s == HOLD_BUS);
  endfunction

endpackage

// File: rtl/hold_flush_cnt.sv
// Loadable 3-bit down-counter timing the bubble window after a redirect.
// Latency: count/last update one cycle after load/en.
// Backpressure: none; saturates at 1 so it can never wrap.
// Ports: clk, rst (async active-low), load + load_val (priority over en),
//        en (decrement), last (count == 1).
module hold_flush_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [2:0] load_val,
  output logic       last
);

  logic [2:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 3'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt > 3'd1)) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign last = (cnt == 3'd1);

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Central pipeline hold/flush controller: arbitrates jump, interrupt, divider
// and bus requests into per-stage hold flags and a registered PC redirect.
// Latency: 1 cycle from a sampled request to the registered outputs.
// Backpressure: divider/bus stalls hold every stage until the source releases.
// Ports: clk, rst (async active-low); jumpFlag/jumpAddr from EX; divBusy;
//        busReq/busGrant; intReq/intAddr -> intAck; holdPc/holdIfId/holdIdEx;
//        redirect/redirectAddr.
// Build option: define HOLD_IRQ_EN to build interrupt entry (INT_ENTER state,
// intAck, intAddr latch); otherwise intReq/intAddr are ignored, intAck is 0.
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int DW           = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jumpFlag,
  input  logic [DW-1:0] jumpAddr,
  input  logic          divBusy,
  input  logic          busReq,
  input  logic          busGrant,
  input  logic          intReq,
  input  logic [DW-1:0] intAddr,
  output logic          intAck,
  output logic          holdPc,
  output logic          holdIfId,
  output logic          holdIdEx,
  output logic          redirect,
  output logic [DW-1:0] redirectAddr
);

  // Interrupt entry already spends one bubble cycle in INT_ENTER, so the
  // following flush is one cycle shorter.
  localparam logic [2:0] FLUSH_LD     = 3'(FLUSH_CYCLES);
  localparam logic [2:0] FLUSH_LD_INT = 3'(FLUSH_CYCLES - 1);

  hold_state_t   state, state_nxt;
  logic          cnt_load, cnt_last;
  logic [2:0]    cnt_ld_val;
  logic          bus_wait;
  logic          int_take;
  logic [DW-1:0] int_addr;
  logic          redirect_nxt;
  logic [DW-1:0] addr_nxt;

  assign bus_wait = busReq && !busGrant;

`ifdef HOLD_IRQ_EN
  assign int_take = intReq;
  assign int_addr = intAddr;
`else
  logic unused_irq;
  assign int_take   = 1'b0;
  assign int_addr   = '0;
  assign unused_irq = ^{intReq, intAddr};
`endif

  hold_flush_cnt u_flush_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (state == HOLD_FLUSH),
    .load_val (cnt_ld_val),
    .last     (cnt_last)
  );

  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_ld_val   = FLUSH_LD;
    redirect_nxt = 1'b0;
    addr_nxt     = redirectAddr;
    case (state)
      HOLD_IDLE: begin
        if (jumpFlag) begin
          state_nxt    = HOLD_FLUSH;
          cnt_load     = 1'b1;
          redirect_nxt = 1'b1;
          addr_nxt     = jumpAddr;
        end else if (int_take) begin
          state_nxt    = HOLD_INT;
          redirect_nxt = 1'b1;
          addr_nxt     = int_addr;
        end else if (divBusy) begin
          state_nxt = HOLD_DIV;
        end else if (bus_wait) begin
          state_nxt = HOLD_BUS;
        end
      end
      // jumpFlag is ignored here: EX only carries a bubble while flushing.
      HOLD_FLUSH: begin
        if (cnt_last) state_nxt = HOLD_IDLE;
      end
      // Leaving a stall always passes through IDLE, which is where any
      // interrupt that arrived meanwhile gets picked up.
      HOLD_DIV: begin
        if (!divBusy) state_nxt = HOLD_IDLE;
      end
      HOLD_BUS: begin
        if (!bus_wait) state_nxt = HOLD_IDLE;
      end
      HOLD_INT: begin
        if (FLUSH_CYCLES == 1) begin
          state_nxt = HOLD_IDLE;
        end else begin
          state_nxt  = HOLD_FLUSH;
          cnt_load   = 1'b1;
          cnt_ld_val = FLUSH_LD_INT;
        end
      end
      default: state_nxt = HOLD_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet still
  // line up with the cycle the new state is active.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= HOLD_IDLE;
      holdPc       <= HOLD_OFF;
      holdIfId     <= HOLD_OFF;
      holdIdEx     <= HOLD_OFF;
      redirect     <= 1'b0;
      redirectAddr <= '0;
    end else begin
      state        <= state_nxt;
      holdPc       <= is_stall(state_nxt) ? HOLD_ON : HOLD_OFF;
      holdIfId     <= (state_nxt != HOLD_IDLE) ? HOLD_ON : HOLD_OFF;
      holdIdEx     <= (state_nxt != HOLD_IDLE) ? HOLD_ON : HOLD_OFF;
      redirect     <= redirect_nxt;
      redirectAddr <= addr_nxt;
    end
  end

`ifdef HOLD_IRQ_EN
  // INT_ENTER is only ever one cycle long, so the ack pulse is simply "in it".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      intAck <= 1'b0;
    end else begin
      intAck <= (state_nxt == HOLD_INT);
    end
  end
`else
  assign intAck = 1'b0;
`endif

`ifndef SYNTHESIS
  // EX is held during a stall, so a jump here means an upstream bug.
  jump_in_stall_a: assert property (@(posedge clk) disable iff (!rst)
    ((state == HOLD_DIV) || (state == HOLD_BUS)) |-> !jumpFlag);
`endif

endmodule
